// File: rtl/pixel_rx.sv
// pixel_rx: decodes a WS2812-style single-wire stream back into 24-bit GRB pixels,
// flags malformed frames and reports the pixel count at each latch gap.
module pixel_rx #(
    parameter int THRESH_TICKS   = 9,
    parameter int MIN_HIGH_TICKS = 3,
    parameter int MAX_HIGH_TICKS = 20,
    parameter int RESET_TICKS    = 800,
    parameter int BITS           = 24,
    parameter int LEDS           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       pixel_valid,
    output logic [7:0] g,
    output logic [7:0] r,
    output logic [7:0] b,
    output logic [4:0] pixel_index,
    output logic       frame_done,
    output logic       frame_error,
    output logic [4:0] pixel_count
);

    localparam int LOW_W = $clog2(RESET_TICKS + 1);
    localparam int BIT_W = $clog2(BITS + 1);

    localparam logic [7:0]       THRESH_C   = 8'(THRESH_TICKS);
    localparam logic [7:0]       MIN_HIGH_C = 8'(MIN_HIGH_TICKS);
    localparam logic [7:0]       MAX_HIGH_C = 8'(MAX_HIGH_TICKS);
    localparam logic [LOW_W-1:0] GAP_C      = LOW_W'(RESET_TICKS);
    localparam logic [BIT_W-1:0] LAST_BIT_C = BIT_W'(BITS - 1);
    localparam logic [4:0]       LEDS_C     = 5'(LEDS);

    localparam logic [2:0] S_SYNC  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    logic             din_meta_q, din_s_q, din_dly_q;
    logic [7:0]       high_cnt_q, high_cnt_d;
    logic [LOW_W-1:0] low_cnt_q, low_cnt_d;
    logic [2:0]       state_q, state_d;
    logic [BITS-1:0]  shift_q, shift_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [4:0]       pix_cnt_q, pix_cnt_d;
    logic             err_q, err_d;
    logic             complete_q, complete_d;
    logic             pixel_valid_q, pixel_valid_d;
    logic [7:0]       g_q, g_d, r_q, r_d, b_q, b_d;
    logic [4:0]       pixel_index_q, pixel_index_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_error_q, frame_error_d;
    logic [4:0]       pixel_count_q, pixel_count_d;

    logic rise, fall, gap, bad_width, end_frame;

    assign rise      = din_s_q & ~din_dly_q;
    assign fall      = ~din_s_q & din_dly_q;
    assign gap       = (low_cnt_q == GAP_C);
    assign bad_width = (high_cnt_q < MIN_HIGH_C) || (high_cnt_q > MAX_HIGH_C);

    always_comb begin
        high_cnt_d = high_cnt_q;
        if (rise)
            high_cnt_d = 8'd1;
        else if (din_s_q && high_cnt_q != 8'hFF)
            high_cnt_d = high_cnt_q + 8'd1;

        // Low count is meaningless while the line is high; clearing it keeps
        // a stale near-gap value from ever surviving a pulse.
        low_cnt_d = low_cnt_q;
        if (din_s_q)
            low_cnt_d = '0;
        else if (fall)
            low_cnt_d = LOW_W'(1);
        else if (low_cnt_q != GAP_C)
            low_cnt_d = low_cnt_q + LOW_W'(1);
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        err_d         = err_q;
        complete_d    = 1'b0;
        pixel_valid_d = 1'b0;
        g_d           = g_q;
        r_d           = r_q;
        b_d           = b_q;
        pixel_index_d = pixel_index_q;
        frame_done_d  = 1'b0;
        frame_error_d = frame_error_q;
        pixel_count_d = pixel_count_q;
        end_frame     = 1'b0;

        // The last bit landed in shift_q on the previous edge; publish it now.
        if (complete_q) begin
            if (pix_cnt_q == LEDS_C) begin
                err_d = 1'b1;
            end else begin
                pixel_valid_d = 1'b1;
                g_d           = shift_q[23:16];
                r_d           = shift_q[15:8];
                b_d           = shift_q[7:0];
                pixel_index_d = pix_cnt_q;
                pix_cnt_d     = pix_cnt_q + 5'd1;
            end
        end

        case (state_q)
            S_SYNC: if (gap) state_d = S_IDLE;
            S_IDLE: if (rise) state_d = S_HIGH;
            S_HIGH: begin
                if (fall) begin
                    if (bad_width) begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end else begin
                        shift_d = {shift_q[BITS-2:0], (high_cnt_q >= THRESH_C)};
                        state_d = S_LOW;
                        if (bit_cnt_q == LAST_BIT_C) begin
                            bit_cnt_d  = '0;
                            complete_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end
                end else if (din_s_q && high_cnt_q > MAX_HIGH_C) begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end
            end
            S_LOW: begin
                if (rise)
                    state_d = S_HIGH;
                else if (gap)
                    end_frame = 1'b1;
            end
            S_ERROR: if (gap) end_frame = 1'b1;
            default: state_d = S_SYNC;
        endcase

        if (end_frame) begin
            frame_done_d  = 1'b1;
            frame_error_d = err_q | (bit_cnt_q != '0);
            pixel_count_d = pix_cnt_q;
            err_d         = 1'b0;
            bit_cnt_d     = '0;
            pix_cnt_d     = '0;
            shift_d       = '0;
            state_d       = S_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_meta_q    <= 1'b0;
            din_s_q       <= 1'b0;
            din_dly_q     <= 1'b0;
            high_cnt_q    <= '0;
            low_cnt_q     <= '0;
            state_q       <= S_SYNC;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            pix_cnt_q     <= '0;
            err_q         <= 1'b0;
            complete_q    <= 1'b0;
            pixel_valid_q <= 1'b0;
            g_q           <= '0;
            r_q           <= '0;
            b_q           <= '0;
            pixel_index_q <= '0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            pixel_count_q <= '0;
        end else begin
            din_meta_q    <= din;
            din_s_q       <= din_meta_q;
            din_dly_q     <= din_s_q;
            high_cnt_q    <= high_cnt_d;
            low_cnt_q     <= low_cnt_d;
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            err_q         <= err_d;
            complete_q    <= complete_d;
            pixel_valid_q <= pixel_valid_d;
            g_q           <= g_d;
            r_q           <= r_d;
            b_q           <= b_d;
            pixel_index_q <= pixel_index_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
            pixel_count_q <= pixel_count_d;
        end
    end

    assign pixel_valid = pixel_valid_q;
    assign g           = g_q;
    assign r           = r_q;
    assign b           = b_q;
    assign pixel_index = pixel_index_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;
    assign pixel_count = pixel_count_q;

endmodule

// File: doc/pixel_rx.md
Name: pixel_rx

Overview:
- Decodes a single-wire WS2812-style pixel stream back into 24-bit GRB pixel words. It is the receive-side counterpart of the team's pixel stream transmitter.
- Used as a loopback checker on the LED output pin and as an input stage for daisy-chained boards.
- Measures each high pulse to classify bits, assembles pixels, and detects the low-level latch gap that ends a frame.

Parameters:
- THRESH_TICKS, 9: high width >= this decodes as 1, below decodes as 0 (midpoint of 6/12-tick T0H/T1H).
- MIN_HIGH_TICKS, 3: high width below this is a glitch, which is a framing error.
- MAX_HIGH_TICKS, 20: high width above this is a framing error.
- RESET_TICKS, 800: consecutive low cycles that constitute the latch/frame gap.
- BITS, 24: bits per pixel.
- LEDS, 8: maximum pixels accepted per frame.

Ports:
- clk  in  1  system clock, same tick rate as the transmitter.
- rst  in  1  reset.
- din  in  1  asynchronous serial line.
- pixel_valid  out  1  one-cycle strobe; g/r/b/pixel_index are valid this cycle.
- g  out  8  green byte (first byte on the wire).
- r  out  8  red byte.
- b  out  8  blue byte (last byte on the wire).
- pixel_index  out  5  position of this pixel in the frame, starting at 0.
- frame_done  out  1  one-cycle strobe when the latch gap is detected.
- frame_error  out  1  valid with frame_done; 1 if the frame was malformed.
- pixel_count  out  5  pixels delivered in the frame just ended; valid with frame_done, held until the next frame_done.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk. rst dominates every other event in the same cycle.
- Reset values:
  - All outputs are 0.
  - FSM enters SYNC.
  - Synchronizer flops are 0.
  - Counters and the shift register are 0.
  - The error flag is clear.
- Input path: din passes through a 2-flop synchronizer to give din_s; din_q is din_s delayed one cycle.
  - rise = din_s & ~din_q.
  - fall = ~din_s & din_q.
- high_cnt: counts cycles with din_s=1. It loads 1 on rise, increments while high, and saturates at 255.
- low_cnt: counts cycles with din_s=0. It loads 1 on fall, increments while low, and saturates at RESET_TICKS.
- FSM states:
  - SYNC: ignores all edges until low_cnt reaches RESET_TICKS, then goes to IDLE. No frame_done is issued on this first gap. A rise before the gap restarts the low count.
  - IDLE: on rise, goes to HIGH.
  - HIGH: on fall, classifies width w = high_cnt.
    - If w < MIN_HIGH_TICKS or w > MAX_HIGH_TICKS, set err and go to ERROR.
    - Otherwise shift bit (w >= THRESH_TICKS) into the LSB of a 24-bit register and go to LOW. bit_cnt increments.
    - If din_s is still high when high_cnt exceeds MAX_HIGH_TICKS, set err and go to ERROR without waiting for the fall.
  - LOW: on rise, goes to HIGH. When low_cnt reaches RESET_TICKS, this is end of frame (see below). Any low gap shorter than RESET_TICKS is tolerated.
  - ERROR: discards all edges until low_cnt reaches RESET_TICKS, then performs end of frame with frame_error=1.
- Pixel assembly: on the fall that completes bit BITS-1:
  - The next cycle, pixel_valid=1, with g/r/b equal to shift bits [23:16]/[15:8]/[7:0] and pixel_index = pix_cnt.
  - bit_cnt returns to 0 and pix_cnt increments.
- Latency: pixel_valid rises on the 3rd clk edge after the first edge that samples the final falling din level.
- Overflow: if pix_cnt == LEDS when a pixel completes, the pixel is discarded (no pixel_valid) and err is set. pix_cnt saturates at LEDS.
- End of frame: issued for the LOW or ERROR states only, never IDLE or SYNC.
  - frame_done=1 for one cycle.
  - frame_error = err | (bit_cnt != 0).
  - pixel_count = pix_cnt.
  - Then err, bit_cnt, pix_cnt and the shift register are cleared, and the FSM goes to IDLE.
- Idle line: a line held low indefinitely produces exactly one frame_done per frame and no repeats, because low_cnt saturates.
- Reset mid-frame: the partial pixel is lost and no frame_done is issued. The block re-requires a full RESET_TICKS gap (SYNC) before decoding.
- g/r/b/pixel_index hold their last values between strobes.

Test Plan:
1. rst, then 800 low cycles, then a transmitter-timed frame of 8 pixels with GRB=0xFF0000, 0x00FF00, …, bits of 6/12-tick highs in 25-tick periods, then 1600 low.
   -> 8 pixel_valid strobes, index 0..7, correct bytes; one frame_done with frame_error=0 and pixel_count=8.
2. Single pixel 0xA5_5A_C3, then 800 low.
   -> g=0xA5, r=0x5A, b=0xC3, index 0; frame_done with pixel_count=1 and frame_error=0; no second frame_done while the line stays low.
3. High-width boundaries, 8 ticks vs 9 ticks.
   -> decoded 0 and 1 respectively; a 2-tick high and a 21-tick high each give frame_error=1 at the next gap, with no pixel_valid after the bad bit.
4. 30 bits (one pixel plus 6 bits), then gap.
   -> one pixel_valid; frame_done with frame_error=1 and pixel_count=1.
5. 9 pixels with LEDS=8.
   -> 8 strobes, the 9th is discarded; frame_error=1 and pixel_count=8.
6. rst asserted after pixel 3 bit 10; deasserted; a valid frame sent immediately without a gap, then a gap, then a valid 2-pixel frame.
   -> no output from the first (SYNC) frame, and no frame_done until the later 2-pixel frame, which reports pixel_count=2 and frame_error=0.
